// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// A granted operation is latched, presented to the ALU for one cycle
// (EXEC), and its result plus flags are held in RESP until the consumer
// accepts them.
module alu_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_opA,
    input  logic [31:0] req0_opB,
    input  logic [4:0]  req0_opcode,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_opA,
    input  logic [31:0] req1_opB,
    input  logic [4:0]  req1_opcode,
    input  logic [4:0]  req1_shamt,
    output logic [31:0] alu_opA,
    output logic [31:0] alu_opB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic        alu_isNotEqual,
    input  logic        alu_isLessThan,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_ne,
    output logic        rsp_lt,
    output logic        rsp_ovf,
    output logic        rsp_illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] opa_q, opb_q;
    logic [4:0]  opcode_q, shamt_q;
    logic        id_q;
    logic [31:0] rsp_result_q;
    logic        rsp_ne_q, rsp_lt_q, rsp_ovf_q, rsp_illegal_q, rsp_id_q;

    logic        grant_id;
    logic        any_valid;
    logic        accept;
    logic        illegal_op;

    // Round-robin choice: contested grants go to the requester that did not win last.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = ~req0_valid;
        end
    end

    // Grants are only offered in IDLE, and never while reset is held.
    assign accept     = (state_q == S_IDLE) && any_valid && !reset;
    assign req0_ready = accept && (grant_id == 1'b0);
    assign req1_ready = accept && (grant_id == 1'b1);

    // Legal opcodes are 00000..00101; everything else is flagged and zeroed.
    assign illegal_op = (opcode_q[4:3] != 2'b00) || (opcode_q[2:1] == 2'b11);

    // Next-state and last_grant update; last_grant only moves on acceptance.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_EXEC;
                    last_grant_d = grant_id;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and arbitration history registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers
            // sample the same pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Operand latch: captures the granted requester's operation on acceptance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: these are plain flops, so clearing them in reset is cheap and
            // keeps the ALU inputs defined from the first cycle.
            opa_q    <= '0;
            opb_q    <= '0;
            opcode_q <= '0;
            shamt_q  <= '0;
            id_q     <= 1'b0;
        end else if (accept) begin
            id_q <= grant_id;
            if (grant_id) begin
                opa_q    <= req1_opA;
                opb_q    <= req1_opB;
                opcode_q <= req1_opcode;
                shamt_q  <= req1_shamt;
            end else begin
                opa_q    <= req0_opA;
                opb_q    <= req0_opB;
                opcode_q <= req0_opcode;
                shamt_q  <= req0_shamt;
            end
        end
    end

    // Response capture at the end of EXEC; values then hold until the next EXEC.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_result_q  <= '0;
            rsp_ne_q      <= 1'b0;
            rsp_lt_q      <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_id_q      <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_id_q      <= id_q;
            rsp_illegal_q <= illegal_op;
            if (illegal_op) begin
                rsp_result_q <= '0;
                rsp_ne_q     <= 1'b0;
                rsp_lt_q     <= 1'b0;
                rsp_ovf_q    <= 1'b0;
            end else begin
                rsp_result_q <= alu_result;
                rsp_ne_q     <= alu_isNotEqual;
                rsp_lt_q     <= alu_isLessThan;
                rsp_ovf_q    <= alu_overflow;
            end
        end
    end

    assign alu_opA     = opa_q;
    assign alu_opB     = opb_q;
    assign alu_opcode  = opcode_q;
    assign alu_shamt   = shamt_q;

    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_ne      = rsp_ne_q;
    assign rsp_lt      = rsp_lt_q;
    assign rsp_ovf     = rsp_ovf_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule
